doe_sbox_sub_bytes: RTL

// - Iterative forward SubBytes engine for the DOE encipher and key-expansion datapaths.
// - Counterpart of the inverse S-box used on the decipher path.
// - Accepts one block of NUM_WORDS 32-bit words and substitutes every byte through one

---
 rtl/doe_sbox_sub_bytes.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/doe_sbox_sub_bytes.sv
// Iterative forward AES SubBytes engine: one 32-bit word per cycle through a shared 4-lane S-box.
// Define DOE_SBOX_SUB_PIPE_EN to register the S-box output word and add a WB write-back state.
module doe_sbox_sub_bytes #(
    parameter int NUM_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   zeroize,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [32*NUM_WORDS-1:0] block_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [32*NUM_WORDS-1:0] block_out,
    output logic                   busy
);

    // state | meaning
    // IDLE  | waiting for a block, in_ready=1
    // SUB   | substituting the word at word_ctr (pipe build: issuing its lookup)
    // WB    | pipe build only: writing the registered S-box word back
    // DONE  | presenting the substituted block until out_ready
    typedef enum logic [1:0] {IDLE, SUB, WB, DONE} state_t;

    localparam int         BW   = 32 * NUM_WORDS;
    localparam logic [2:0] LAST = 3'(NUM_WORDS - 1);

    // Row r holds S(r0)..S(rf); S(00) sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    state_t      state, state_next;
    logic [BW-1:0] block_q, block_d;
    logic [2:0]  word_ctr, ctr_d;
    logic [31:0] cur_word, sub_word, wr_word;
    logic        adv;

`ifdef DOE_SBOX_SUB_PIPE_EN
    logic [31:0] pipe_q, pipe_d;
    assign wr_word = pipe_q;
`else
    assign wr_word = sub_word;
`endif

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_WORDS; i++)
            if (word_ctr == 3'(i)) cur_word = block_q[32*(NUM_WORDS-1-i) +: 32];
    end

    assign sub_word = {sbox(cur_word[31:24]), sbox(cur_word[23:16]),
                       sbox(cur_word[15:8]),  sbox(cur_word[7:0])};

    always_comb begin
        state_next = state;
        block_d    = block_q;
        ctr_d      = word_ctr;
        adv        = 1'b0;
`ifdef DOE_SBOX_SUB_PIPE_EN
        pipe_d     = pipe_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    block_d    = block_in;
                    ctr_d      = '0;
                    state_next = SUB;
                end
            end
`ifdef DOE_SBOX_SUB_PIPE_EN
            SUB: begin
                pipe_d     = sub_word;
                state_next = WB;
            end
            WB:   adv = 1'b1;
`else
            SUB:  adv = 1'b1;
`endif
            DONE: begin
                if (out_ready) begin
                    block_d    = '0;
                    ctr_d      = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                block_d    = '0;
                ctr_d      = '0;
                state_next = IDLE;
            end
        endcase

        if (adv) begin
            for (int i = 0; i < NUM_WORDS; i++)
                if (word_ctr == 3'(i)) block_d[32*(NUM_WORDS-1-i) +: 32] = wr_word;
            if (word_ctr == LAST) state_next = DONE;
            else                  ctr_d      = word_ctr + 3'd1;
`ifdef DOE_SBOX_SUB_PIPE_EN
            if (word_ctr != LAST) state_next = SUB;
`endif
        end

        // A corrupted counter must never let a half-substituted block escape.
        if (word_ctr > LAST) begin
            block_d    = '0;
            ctr_d      = '0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || zeroize) begin
            state    <= IDLE;
            block_q  <= '0;
            word_ctr <= '0;
`ifdef DOE_SBOX_SUB_PIPE_EN
            pipe_q   <= '0;
`endif
        end else begin
            state    <= state_next;
            block_q  <= block_d;
            word_ctr <= ctr_d;
`ifdef DOE_SBOX_SUB_PIPE_EN
            pipe_q   <= pipe_d;
`endif
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign block_out = out_valid ? block_q : '0;

endmodule
